// File: rtl/conv_stream_feeder_if.sv
// AXI4-Stream link from the frame feeder to the conv core.
// master drives tdata/tvalid/tlast, slave drives tready.
interface conv_stream_feeder_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// Streams one conv frame (kernel block + image) from BRAM onto AXI4-Stream.
// Ports: clk/Reset_top, start + choose/base config, BRAM read port,
// m_axis stream master, busy/feed_DONE/words_sent status.
module conv_stream_feeder #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  Reset_top,
  input  logic                  start,
  input  logic [1:0]            CHANNEL_SIZE_choose,
  input  logic [2:0]            IMAGE_SIZE_choose,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  conv_stream_feeder_if.master  m_axis,
  output logic                  busy,
  output logic                  feed_DONE,
  output logic [ADDR_WIDTH-1:0] words_sent
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  // channels * (side^2 + 1); side saturates at 64
  function automatic logic [ADDR_WIDTH-1:0] frame_words(
    input logic [1:0] c,
    input logic [2:0] s
  );
    logic [2:0]  sc;
    logic [6:0]  side;
    logic [12:0] sq;
    logic [8:0]  ch;
    sc   = (s > 3'd4) ? 3'd4 : s;
    side = 7'd4 << sc;
    sq   = 13'(side) * 13'(side) + 13'd1;
    ch   = 9'd256 >> c;
    return ADDR_WIDTH'(ch) * ADDR_WIDTH'(sq);
  endfunction

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] total_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [ADDR_WIDTH-1:0] words_q;
  logic [ADDR_WIDTH-1:0] words_d;
  logic                  busy_q;
  logic                  done_q;

  // read issued last cycle; its data lands in the buffer this edge
  logic                  rd_vld_q;
  logic                  rd_last_q;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;

  logic                  tvalid;
  logic                  pop;
  logic                  rd_go;
  logic                  is_last_rd;
  logic [2:0]            occ;

  // Read gating counts this cycle's pop so a full-rate stream keeps
  // one word buffered and one in flight. tready only reaches bram_en,
  // never tvalid/tdata.
  always_comb begin
    tvalid     = (cnt_q != 2'd0);
    pop        = tvalid & m_axis.tready;
    occ        = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    rd_go      = (state_q == FETCH) && (occ < 3'd2);
    is_last_rd = (issued_q == total_q - ADDR_WIDTH'(1));
    cnt_d      = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    words_d    = pop ? words_q + ADDR_WIDTH'(1) : words_q;
  end

  assign bram_en       = rd_go;
  assign bram_addr     = base_q + issued_q;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = buf_data_q[rd_ptr_q];
  assign m_axis.tlast  = tvalid & buf_last_q[rd_ptr_q];
  assign busy          = busy_q;
  assign feed_DONE     = done_q;
  assign words_sent    = words_q;

  always_ff @(posedge clk or posedge Reset_top) begin
    if (Reset_top) begin
      state_q       <= IDLE;
      total_q       <= '0;
      base_q        <= '0;
      issued_q      <= '0;
      words_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
    end else begin
      done_q    <= 1'b0;
      rd_vld_q  <= rd_go;
      rd_last_q <= rd_go & is_last_rd;
      cnt_q     <= cnt_d;
      words_q   <= words_d;

      if (rd_vld_q) begin
        buf_data_q[wr_ptr_q] <= bram_dout;
        buf_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            total_q  <= frame_words(CHANNEL_SIZE_choose,
                                    IMAGE_SIZE_choose);
            base_q   <= base_addr;
            issued_q <= '0;
            words_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          if (rd_go) begin
            issued_q <= issued_q + ADDR_WIDTH'(1);
            if (is_last_rd) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_axis.tlast) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench for conv_stream_feeder: BRAM model, tready driver,
// directed frames, and a negedge monitor checking the stream.
module tb_conv_stream_feeder;
  localparam int DW = 256;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          Reset_top = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    csel = 2'd0;
  logic [2:0]    ssel = 3'd0;
  logic [AW-1:0] base = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic          busy;
  logic          feed_DONE;
  logic [AW-1:0] words_sent;

  conv_stream_feeder_if #(.DATA_WIDTH(DW)) axis ();

  conv_stream_feeder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk                (clk),
    .Reset_top          (Reset_top),
    .start              (start),
    .CHANNEL_SIZE_choose(csel),
    .IMAGE_SIZE_choose  (ssel),
    .base_addr          (base),
    .bram_en            (bram_en),
    .bram_addr          (bram_addr),
    .bram_dout          (bram_dout),
    .m_axis             (axis),
    .busy               (busy),
    .feed_DONE          (feed_DONE),
    .words_sent         (words_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            vectors = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            hs_cnt = 0;
  int            rd_cnt = 0;
  int            mode = 0;
  longint        cyc = 0;
  longint        hs_first = -1;
  longint        hs_last = -1;
  logic [AW-1:0] exp_words = '0;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {11'h5A5, a};
    return {{4{w ^ 32'hC3C3_3C3C}}, {4{w}}};
  endfunction

  task automatic chk(input string n, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chk_i(input string n, input longint act,
                       input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // synchronous BRAM, one cycle read latency
  always @(posedge clk) begin
    cyc++;
    if (bram_en) bram_dout <= word_of(bram_addr);
  end

  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: axis.tready = 1'b1;
        1: axis.tready = 1'($urandom_range(0, 1));
        default: axis.tready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every handshake
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (Reset_top) begin
      prev_stall = 1'b0;
    end else begin
      if (bram_en) rd_cnt++;
      if (prev_stall) begin
        chk_i("hold_valid", axis.tvalid, 1);
        chk("hold_data", axis.tdata, prev_d);
        chk_i("hold_last", axis.tlast, prev_l);
      end
      if (axis.tvalid && axis.tready) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL extra_word: got %h want none", axis.tdata);
        end else begin
          e = q.pop_front();
          chk("tdata", axis.tdata, e.d);
          chk_i("tlast", axis.tlast, e.l);
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_d     = axis.tdata;
      prev_l     = axis.tlast;
      if (feed_DONE) begin
        done_cnt++;
        chk_i("words_at_done", words_sent, exp_words);
        chk_i("busy_at_done", busy, 0);
      end
    end
  end

  task automatic push_frame(input logic [AW-1:0] b, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = word_of(b + AW'(i));
      e.l = (i == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic kick(input logic [1:0] c, input logic [2:0] s,
                      input logic [AW-1:0] b, input int n);
    push_frame(b, n);
    exp_words = AW'(n);
    hs_first  = -1;
    @(posedge clk);
    #1;
    csel  = c;
    ssel  = s;
    base  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rd_cnt = 0;
  endtask

  task automatic wait_done(input int target, input int budget,
                           input string n);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk_i(n, done_cnt, target);
    chk_i({n, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int h0;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_bram_en", bram_en, 0);
    chk_i("rst_bram_addr", bram_addr, 0);
    chk_i("rst_tvalid", axis.tvalid, 0);
    chk_i("rst_tlast", axis.tlast, 0);
    chk("rst_tdata", axis.tdata, '0);
    chk_i("rst_busy", busy, 0);
    chk_i("rst_done", feed_DONE, 0);
    chk_i("rst_words", words_sent, 0);
    @(posedge clk);
    #1;
    Reset_top = 1'b0;

    // 256 ch, 4x4, full rate
    mode = 0;
    kick(2'd0, 3'd0, '0, 4352);
    @(negedge clk);
    chk_i("lat_busy", busy, 1);
    chk_i("lat_e0", axis.tvalid, 0);
    @(negedge clk);
    chk_i("lat_e1", axis.tvalid, 0);
    @(negedge clk);
    chk_i("lat_e2", axis.tvalid, 1);
    wait_done(1, 5000, "run1_done");
    chk_i("run1_no_bubble", hs_last - hs_first, 4351);
    chk_i("run1_words", words_sent, 4352);
    @(negedge clk);
    chk_i("run1_done_pulse", feed_DONE, 0);

    // 32 ch, random back-pressure
    mode = 1;
    kick(2'd3, 3'd0, '0, 544);
    wait_done(2, 4000, "run2_done");

    // long stall from the start: only two reads may be outstanding
    mode = 2;
    kick(2'd3, 3'd0, AW'(100), 544);
    repeat (22) @(negedge clk);
    chk_i("stall_reads", rd_cnt, 2);
    chk_i("stall_valid", axis.tvalid, 1);
    mode = 0;
    wait_done(3, 2000, "run3_done");

    // address wrap past the top of BRAM
    mode = 1;
    kick(2'd3, 3'd0, 21'h1F_FFFB, 544);
    wait_done(4, 4000, "run4_done");

    // abort mid-frame with reset, then 64 ch 8x8
    mode = 0;
    h0 = hs_cnt;
    kick(2'd0, 3'd0, '0, 4352);
    k = 0;
    while (hs_cnt < h0 + 100 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    chk_i("abort_reached", hs_cnt >= h0 + 100, 1);
    @(posedge clk);
    #2;
    Reset_top = 1'b1;
    #1;
    chk_i("abort_tvalid", axis.tvalid, 0);
    chk_i("abort_busy", busy, 0);
    chk_i("abort_words", words_sent, 0);
    chk_i("abort_bram_en", bram_en, 0);
    chk("abort_tdata", axis.tdata, '0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    Reset_top = 1'b0;
    repeat (5) @(negedge clk);
    chk_i("abort_no_done", done_cnt, 4);
    kick(2'd2, 3'd1, '0, 4160);
    wait_done(5, 6000, "run5_done");

    // start held high, config toggled mid-frame
    mode = 0;
    push_frame(AW'(64), 544);
    push_frame(AW'(64), 544);
    exp_words = AW'(544);
    @(posedge clk);
    #1;
    csel  = 2'd3;
    ssel  = 3'd0;
    base  = AW'(64);
    start = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    csel = 2'd0;
    ssel = 3'd7;
    base = AW'(21'h1234);
    repeat (100) @(posedge clk);
    #1;
    csel = 2'd3;
    ssel = 3'd0;
    base = AW'(64);
    k = 0;
    while (done_cnt < 6 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk_i("run6_frame1", done_cnt, 6);
    #1;
    chk_i("run6_restart_busy", busy, 1);
    chk_i("run6_restart_done", feed_DONE, 0);
    repeat (30) @(posedge clk);
    #1;
    csel  = 2'd1;
    ssel  = 3'd2;
    start = 1'b0;
    wait_done(7, 2000, "run6_frame2");
    repeat (5) @(posedge clk);
    #1;
    chk_i("run6_idle", busy, 0);
    chk_i("run6_done_total", done_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- AXI4-Stream master that streams the convolution input frame from a local 256-bit BRAM into top_level_conv's s_axis port. The frame is one kernel block followed by the full input image.
- Replaces the DMA/MM2S source: reads `CHANNEL_SIZE*(IMAGE_SIZE^2+1)` consecutive words, handles the 1-cycle BRAM read latency and back-pressure with a 2-entry output buffer, and asserts tlast on the final word.

Parameters:
- DATA_WIDTH, 256, stream/BRAM word width
- ADDR_WIDTH, 21, BRAM word-address width; must cover at least 1,048,832 words

Ports:
- clk  in  1  system clock; all logic on rising edge
- Reset_top  in  1  asynchronous active-high reset
- start  in  1  level-sampled start request; accepted only in IDLE
- CHANNEL_SIZE_choose  in  2  channels = 256 >> value (256/128/64/32)
- IMAGE_SIZE_choose  in  3  side = 4 << value (4..64); values 5-7 saturate to 64
- base_addr  in  ADDR_WIDTH  BRAM word address of the frame's first word
- bram_en  out  1  BRAM read enable
- bram_addr  out  ADDR_WIDTH  BRAM read address
- bram_dout  in  DATA_WIDTH  BRAM read data, valid one cycle after bram_en
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready from conv core
- m_axis_tlast  out  1  high with the final word only
- busy  out  1  high from start acceptance until feed_DONE
- feed_DONE  out  1  one-cycle pulse after the last handshake
- words_sent  out  ADDR_WIDTH  handshakes completed in the current/last frame

Behaviour:
- Reset values: bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, feed_DONE=0, words_sent=0, buffer empty, state IDLE. Reset mid-frame aborts immediately with no DONE pulse.
- On the edge where start=1 in IDLE:
  - latch the choose inputs and base_addr;
  - compute `total = (256>>C) * ((4<<S)^2 + 1)`;
  - clear words_sent;
  - set busy=1 and go to FETCH.
- Choose/base changes while busy are ignored. start while busy is ignored.
- FETCH:
  - Issue a read (bram_en=1, `bram_addr = base + issued`) in any cycle where `buffered + in-flight < 2`.
  - issued increments per read. When `issued == total`, go to DRAIN.
  - BRAM data is written into the buffer on the edge after its read.
- Output buffer: 2-entry FIFO.
  - m_axis_tvalid = buffer non-empty; tdata/tlast are driven from the head entry.
  - Handshake is tvalid & tready; it pops the head and increments words_sent.
  - tlast is tagged on the entry whose read index equals total-1.
- Latency: first tvalid is 2 edges after the start edge. With tready held high, one word per cycle is sustained with no bubbles.
- AXIS rules: tvalid never deasserts without a handshake. tdata/tlast are held stable while tvalid & !tready. No combinational path from tready to tvalid/tdata.
- Simultaneous pop and push of the buffer in the same cycle is legal; occupancy is unchanged.
- Address arithmetic is modulo 2^ADDR_WIDTH: wrap-around past the top is permitted, not flagged.
- DRAIN: issue no reads; wait for the buffer to empty. On the edge after the tlast handshake:
  - feed_DONE=1 for exactly one cycle;
  - busy=0;
  - state returns to IDLE.
- words_sent holds its final value until the next accepted start or reset.
- A new start may be accepted in the cycle following feed_DONE.

Test Plan:
- C=0, S=0, base=0, tready held high, BRAM word i = i → 4352 words, data 0..4351 in order. tlast only on word 4351. First tvalid 2 edges after start. No idle cycles. feed_DONE single pulse. words_sent=4352.
- C=3, S=0 (32 ch, 4x4), tready random 50% → 544 words, in order, none duplicated or dropped. tdata/tlast stable during every stall. tvalid never drops early.
- tready low for 20 cycles from cycle 3 of the run → bram_en stops after 2 outstanding words, no BRAM read is lost, stream resumes in order.
- base=2^21-5, C=3, S=0 → addresses wrap to 0 after 0x1FFFFF; stream contents follow the wrapped addresses.
- Reset_top pulsed after 100 handshakes, then restart with C=2, S=1 (64 ch, 8x8) → outputs clear immediately, no feed_DONE from the aborted run. The new run sends 4160 words with tlast on the last.
- start held high continuously and choose inputs toggled mid-frame → only the latched config is used, one feed_DONE per frame, next frame starts the cycle after feed_DONE.
